// File: rtl/formant_pkg.sv
// Shared types, constants and arithmetic helpers for the formant DP segmentation datapath.
package formant_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    TRACE,
    OUT
  } dpState_e;

  localparam int SAT_W = 64;
  localparam logic [SAT_W-1:0] COST_INF = '1;

  // Index width that stays at least one bit wide for degenerate ranges.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int               width
  );
    logic [SAT_W:0] sum;
    logic [SAT_W:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
    if (sum > limit) begin
      return limit[SAT_W-1:0];
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/dp_lane.sv
// One DP lane for segment count k: running argmin over a column and F/B column storage.
module dp_lane
  import formant_pkg::*;
#(
  parameter  int BIT_WIDTH = 32,
  parameter  int I         = 160,
  localparam int IW        = idxWidth(I)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [IW-1:0]        col_i,
  input  logic [IW-1:0]        row_i,
  input  logic [IW-1:0]        fRdIdx_i,
  input  logic [IW-1:0]        bRdIdx_i,
  input  logic [BIT_WIDTH-1:0] prevF_i,
  input  logic [BIT_WIDTH-1:0] e_i,
  output logic [BIT_WIDTH-1:0] fRd_o,
  output logic [BIT_WIDTH-1:0] wr_o,
  output logic [IW-1:0]        bRd_o
);

  localparam logic [BIT_WIDTH-1:0] INF = COST_INF[BIT_WIDTH-1:0];

  logic [BIT_WIDTH-1:0] best_q;
  logic [BIT_WIDTH-1:0] best_d;
  logic [BIT_WIDTH-1:0] cand;
  logic [IW-1:0]        bidx_q;
  logic [IW-1:0]        bidx_d;

  logic [BIT_WIDTH-1:0] fMem [0:I-1];
  logic [IW-1:0]        bMem [0:I-1];

  assign cand = BIT_WIDTH'(sat_add(SAT_W'(prevF_i), SAT_W'(e_i), BIT_WIDTH));

  // Row 0 opens a new column; strict compare keeps the earliest split on ties.
  always_comb begin
    best_d = best_q;
    bidx_d = bidx_q;
    if (row_i == '0) begin
      best_d = INF;
      bidx_d = '0;
    end else if (cand < best_q) begin
      best_d = cand;
      bidx_d = row_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_q <= INF;
      bidx_q <= '0;
    end else if (en_i) begin
      best_q <= best_d;
      bidx_q <= bidx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i && (row_i == col_i)) begin
      fMem[col_i] <= best_d;
      bMem[col_i] <= bidx_d;
    end
  end

  assign fRd_o = fMem[fRdIdx_i];
  assign bRd_o = bMem[bRdIdx_i];
  assign wr_o  = best_d;

endmodule

// File: rtl/segment_dp_core.sv
// Runtime-K DP segmentation engine: accumulates E(j,i) into F/B tables, then traces back bounds.
module segment_dp_core
  import formant_pkg::*;
#(
  parameter  int BIT_WIDTH = 32,
  parameter  int I         = 160,
  parameter  int MAX_SEG   = 5,
  localparam int IW        = idxWidth(I),
  localparam int BW        = idxWidth(I + 1),
  localparam int KW        = idxWidth(MAX_SEG + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [KW-1:0]        num_seg_in,
  input  logic                 e_valid_in,
  input  logic [BIT_WIDTH-1:0] e_data_in,
  output logic                 e_ready_out,
  output logic [IW-1:0]        e_i_out,
  output logic [IW-1:0]        e_j_out,
  output logic                 seg_valid_out,
  input  logic                 seg_ready_in,
  output logic [BW-1:0]        seg_bound_out [0:MAX_SEG],
  output logic [BIT_WIDTH-1:0] seg_cost_out,
  output logic                 busy_out,
  output logic                 err_out
);

  if ((MAX_SEG < 1) || (MAX_SEG > I) || (BIT_WIDTH < 1) || (BIT_WIDTH > SAT_W)) begin : gBadParams
    $error("segment_dp_core: illegal parameter set");
  end

  dpState_e             state_q;
  dpState_e             state_d;
  logic [IW-1:0]        col_q;
  logic [IW-1:0]        col_d;
  logic [IW-1:0]        row_q;
  logic [IW-1:0]        row_d;
  logic [IW-1:0]        traceEnd_q;
  logic [IW-1:0]        traceEnd_d;
  logic [KW-1:0]        numSeg_q;
  logic [KW-1:0]        numSeg_d;
  logic [KW-1:0]        traceK_q;
  logic [KW-1:0]        traceK_d;
  logic [BW-1:0]        bound_q [0:MAX_SEG];
  logic [BW-1:0]        bound_d [0:MAX_SEG];
  logic [BIT_WIDTH-1:0] cost_q;
  logic [BIT_WIDTH-1:0] cost_d;
  logic                 err_q;
  logic                 err_d;

  logic                 eAccept;
  logic                 lastSample;
  logic                 badK;
  logic [IW-1:0]        fRdIdx;
  logic [IW-1:0]        traceB;

  logic [BIT_WIDTH-1:0] f1Mem   [0:I-1];
  logic [BIT_WIDTH-1:0] laneFRd [1:MAX_SEG];
  logic [BIT_WIDTH-1:0] laneWr  [1:MAX_SEG];
  logic [IW-1:0]        laneBRd [1:MAX_SEG];

  assign eAccept    = e_valid_in && (state_q == ACCUM);
  assign lastSample = eAccept && (row_q == col_q) && (col_q == IW'(I - 1));
  assign badK       = (num_seg_in == '0) || (int'(num_seg_in) > MAX_SEG);
  assign fRdIdx     = (row_q == '0) ? '0 : row_q - IW'(1);
  assign traceB     = laneBRd[traceK_q];

  // Single-segment costs come straight from the row-0 sample of each column.
  always_ff @(posedge clk_in) begin
    if (eAccept && (row_q == '0)) begin
      f1Mem[col_q] <= e_data_in;
    end
  end

  assign laneFRd[1] = f1Mem[fRdIdx];
  assign laneWr[1]  = (row_q == '0) ? e_data_in : f1Mem[IW'(I - 1)];
  assign laneBRd[1] = '0;

  for (genvar k = 2; k <= MAX_SEG; k++) begin : gLane
    dp_lane #(
      .BIT_WIDTH (BIT_WIDTH),
      .I         (I)
    ) uLane (
      .clk_i    (clk_in),
      .rst_ni   (rst_in),
      .en_i     (eAccept && (int'(numSeg_q) >= k)),
      .col_i    (col_q),
      .row_i    (row_q),
      .fRdIdx_i (fRdIdx),
      .bRdIdx_i (traceEnd_q),
      .prevF_i  (laneFRd[k-1]),
      .e_i      (e_data_in),
      .fRd_o    (laneFRd[k]),
      .wr_o     (laneWr[k]),
      .bRd_o    (laneBRd[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    traceEnd_d = traceEnd_q;
    numSeg_d   = numSeg_q;
    traceK_d   = traceK_q;
    bound_d    = bound_q;
    cost_d     = cost_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (badK) begin
            err_d = 1'b1;
          end else begin
            numSeg_d = num_seg_in;
            col_d    = '0;
            row_d    = '0;
            state_d  = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (eAccept) begin
          if (row_q == col_q) begin
            row_d = '0;
            if (lastSample) begin
              // The final column's writeback value is the optimal cost for K segments.
              col_d      = '0;
              cost_d     = laneWr[numSeg_q];
              traceEnd_d = IW'(I - 1);
              traceK_d   = numSeg_q;
              for (int m = 0; m <= MAX_SEG; m++) begin
                bound_d[m] = (m == 0) ? '0 : BW'(I);
              end
              state_d = (numSeg_q == KW'(1)) ? OUT : TRACE;
            end else begin
              col_d = col_q + IW'(1);
            end
          end else begin
            row_d = row_q + IW'(1);
          end
        end
      end
      TRACE: begin
        bound_d[traceK_q - KW'(1)] = BW'(traceB);
        traceEnd_d = (traceB == '0) ? '0 : traceB - IW'(1);
        traceK_d   = traceK_q - KW'(1);
        if (traceK_q == KW'(2)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (seg_ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      traceEnd_q <= '0;
      numSeg_q   <= '0;
      traceK_q   <= '0;
      for (int m = 0; m <= MAX_SEG; m++) begin
        bound_q[m] <= '0;
      end
      cost_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      traceEnd_q <= traceEnd_d;
      numSeg_q   <= numSeg_d;
      traceK_q   <= traceK_d;
      bound_q    <= bound_d;
      cost_q     <= cost_d;
      err_q      <= err_d;
    end
  end

  assign e_ready_out   = (state_q == ACCUM);
  assign e_i_out       = col_q;
  assign e_j_out       = row_q;
  assign seg_valid_out = (state_q == OUT);
  assign seg_bound_out = bound_q;
  assign seg_cost_out  = cost_q;
  assign busy_out      = (state_q != IDLE);
  assign err_out       = err_q;

endmodule

// File: tb/tb_segment_dp_core.sv
// Directed bench for segment_dp_core at I=6, MAX_SEG=3 with hand-derived golden results.
module tb_segment_dp_core;

  localparam int BIT_WIDTH = 32;
  localparam int I         = 6;
  localparam int MAX_SEG   = 3;
  localparam int IW        = $clog2(I);
  localparam int BW        = $clog2(I + 1);
  localparam int KW        = $clog2(MAX_SEG + 1);

  logic                 clk = 1'b0;
  logic                 rstN = 1'b0;
  logic                 start = 1'b0;
  logic [KW-1:0]        numSeg = '0;
  logic                 eValid = 1'b0;
  logic [BIT_WIDTH-1:0] eData = '0;
  logic                 eReady;
  logic [IW-1:0]        eI;
  logic [IW-1:0]        eJ;
  logic                 segValid;
  logic                 segReady = 1'b1;
  logic [BW-1:0]        segBound [0:MAX_SEG];
  logic [BIT_WIDTH-1:0] segCost;
  logic                 busy;
  logic                 errOut;

  int checks = 0;
  int failures = 0;

  segment_dp_core #(
    .BIT_WIDTH (BIT_WIDTH),
    .I         (I),
    .MAX_SEG   (MAX_SEG)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rstN),
    .start_in      (start),
    .num_seg_in    (numSeg),
    .e_valid_in    (eValid),
    .e_data_in     (eData),
    .e_ready_out   (eReady),
    .e_i_out       (eI),
    .e_j_out       (eJ),
    .seg_valid_out (segValid),
    .seg_ready_in  (segReady),
    .seg_bound_out (segBound),
    .seg_cost_out  (segCost),
    .busy_out      (busy),
    .err_out       (errOut)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  // 0: (i-j)^2, 1: all zero, 2: half-range constant that saturates on any sum.
  function automatic logic [BIT_WIDTH-1:0] costOf(input int pattern, input int i, input int j);
    case (pattern)
      0:       return BIT_WIDTH'((i - j) * (i - j));
      1:       return '0;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic applyStimulus(
    input int                   k,
    input int                   pattern,
    input bit                   gaps,
    input int                   stall,
    input int                   stopAfter,
    input logic [BIT_WIDTH-1:0] expCost,
    input int                   expB1,
    input int                   expB2
  );
    int sent;
    int lat;
    int gap;
    sent = 0;
    segReady = (stall == 0);
    @(negedge clk);
    start  = 1'b1;
    numSeg = KW'(k);
    @(negedge clk);
    start  = 1'b0;
    numSeg = '0;
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    for (int i = 0; i < I; i++) begin
      for (int j = 0; j <= i; j++) begin
        if (gaps) begin
          gap = int'($urandom_range(0, 2));
          for (int g = 0; g < gap; g++) begin
            eValid = 1'b0;
            eData  = '1;
            @(negedge clk);
          end
        end
        checkOutput("e_index", 64'({eI, eJ}), 64'({IW'(i), IW'(j)}));
        checkOutput("e_ready", 64'(eReady), 64'(1));
        eValid = 1'b1;
        eData  = costOf(pattern, i, j);
        @(negedge clk);
        sent++;
        if (sent == stopAfter) begin
          eValid = 1'b0;
          return;
        end
      end
    end
    eValid = 1'b0;
    lat = 1;
    while (!segValid && (lat < 40)) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(k));
    for (int s = 0; s <= stall; s++) begin
      checkOutput("seg_valid", 64'(segValid), 64'(1));
      checkOutput("seg_cost", 64'(segCost), 64'(expCost));
      checkOutput("bound0", 64'(segBound[0]), 64'(0));
      checkOutput("bound1", 64'(segBound[1]), 64'(expB1));
      checkOutput("bound2", 64'(segBound[2]), 64'(expB2));
      checkOutput("bound3", 64'(segBound[3]), 64'(I));
      if (s < stall) @(negedge clk);
    end
    if (stall > 0) begin
      segReady = 1'b1;
      start    = 1'b1;
      numSeg   = KW'(2);
      @(negedge clk);
      start    = 1'b0;
      numSeg   = '0;
    end else begin
      @(negedge clk);
    end
    checkOutput("valid_dropped", 64'(segValid), 64'(0));
    checkOutput("idle_after_ack", 64'(busy), 64'(0));
    if (stall > 0) begin
      @(negedge clk);
      checkOutput("start_ignored_in_ack", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    int badK;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 64'(segValid), 64'(0));
    checkOutput("rst_ready", 64'(eReady), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_err", 64'(errOut), 64'(0));
    checkOutput("rst_cost", 64'(segCost), 64'(0));
    checkOutput("rst_bound3", 64'(segBound[3]), 64'(0));
    rstN = 1'b1;

    applyStimulus(3, 0, 1'b0, 0, -1, 32'd3, 2, 4);
    applyStimulus(1, 0, 1'b0, 0, -1, 32'd25, 6, 6);
    applyStimulus(3, 1, 1'b0, 0, -1, 32'd0, 1, 2);
    applyStimulus(2, 2, 1'b0, 0, -1, 32'hFFFF_FFFF, 0, 6);

    @(negedge clk);
    start  = 1'b1;
    numSeg = '0;
    @(negedge clk);
    start  = 1'b0;
    checkOutput("err_k0", 64'(errOut), 64'(1));
    checkOutput("busy_k0", 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput("err_k0_clear", 64'(errOut), 64'(0));
    badK   = 4;
    start  = 1'b1;
    numSeg = badK[KW-1:0];
    @(negedge clk);
    start  = 1'b0;
    checkOutput("err_k4", 64'(errOut), 64'(1));
    checkOutput("busy_k4", 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput("err_k4_clear", 64'(errOut), 64'(0));

    eValid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_evalid_busy", 64'(busy), 64'(0));
    checkOutput("idle_evalid_ready", 64'(eReady), 64'(0));
    eValid = 1'b0;

    applyStimulus(3, 0, 1'b1, 10, -1, 32'd3, 2, 4);

    applyStimulus(3, 0, 1'b0, 0, 7, 32'd0, 0, 0);
    checkOutput("mid_col", 64'(eI), 64'(3));
    checkOutput("mid_row", 64'(eJ), 64'(1));
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(segValid), 64'(0));
    checkOutput("arst_ready", 64'(eReady), 64'(0));
    checkOutput("arst_busy", 64'(busy), 64'(0));
    checkOutput("arst_err", 64'(errOut), 64'(0));
    checkOutput("arst_col", 64'(eI), 64'(0));
    checkOutput("arst_row", 64'(eJ), 64'(0));
    checkOutput("arst_cost", 64'(segCost), 64'(0));
    checkOutput("arst_bound1", 64'(segBound[1]), 64'(0));
    checkOutput("arst_bound3", 64'(segBound[3]), 64'(0));
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(3, 0, 1'b0, 0, -1, 32'd3, 2, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
